// File: rtl/matmul_row_block_replay_if.sv
// rtl/matmul_row_block_replay_if.sv - operand stream bundle between source, replay stage and matmul consumer
interface matmul_row_block_replay_if #(
  parameter int DATA_WIDTH = 8,
  parameter int BEAT_SIZE  = 4,
  parameter int REPEAT     = 2
);
  localparam int PASS_W = (REPEAT > 1) ? $clog2(REPEAT) : 1;

  logic [DATA_WIDTH-1:0] data_in [BEAT_SIZE];
  logic                  data_in_valid;
  logic                  data_in_ready;
  logic [DATA_WIDTH-1:0] data_out [BEAT_SIZE];
  logic                  data_out_valid;
  logic                  data_out_ready;
  logic                  data_out_last;
  logic                  data_out_block_last;
  logic [PASS_W-1:0]     pass_index;

  // Replay stage view: consumes data_in, produces data_out
  modport slave (
    input  data_in, data_in_valid, data_out_ready,
    output data_in_ready, data_out, data_out_valid,
    output data_out_last, data_out_block_last, pass_index
  );

  // Environment view: source and consumer around the replay stage
  modport master (
    output data_in, data_in_valid, data_out_ready,
    input  data_in_ready, data_out, data_out_valid,
    input  data_out_last, data_out_block_last, pass_index
  );
endinterface

// File: rtl/matmul_row_block_replay.sv
// rtl/matmul_row_block_replay.sv - captures one left-matrix row-block and presents it REPEAT times
module matmul_row_block_replay #(
  parameter int DATA_WIDTH = 8,
  parameter int BEAT_SIZE  = 4,
  parameter int DEPTH      = 3,
  parameter int REPEAT     = 2
) (
  input logic                    clk,
  input logic                    rst,
  matmul_row_block_replay_if.slave bus
);
  localparam int BW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int PW = (REPEAT > 1) ? $clog2(REPEAT) : 1;

  typedef enum logic {FILL, REPLAY} state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [BW-1:0]         r_beat_cnt;
  logic [BW-1:0]         w_beat_nxt;
  logic [PW-1:0]         r_pass_cnt;
  logic [PW-1:0]         w_pass_nxt;
  logic [DATA_WIDTH-1:0] r_mem [DEPTH][BEAT_SIZE];
  logic                  w_xfer;
  logic                  w_beat_last;

  assign w_beat_last = (r_beat_cnt == BW'(DEPTH - 1));
  assign w_xfer      = bus.data_out_valid && bus.data_out_ready;

  // State and counter registers; storage is deliberately left out of reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= FILL;
      r_beat_cnt <= '0;
      r_pass_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_beat_cnt <= w_beat_nxt;
      r_pass_cnt <= w_pass_nxt;
    end
  end

  // Pass-0 beats are written into the row-block store as they stream through
  always_ff @(posedge clk) begin
    if (r_state == FILL && w_xfer) begin
      for (int k = 0; k < BEAT_SIZE; k++) begin
        r_mem[r_beat_cnt][k] <= bus.data_in[k];
      end
    end
  end

  // Next-state, counters and output muxing; FILL is a wire, REPLAY reads the store
  always_comb begin
    w_state_nxt             = r_state;
    w_beat_nxt              = r_beat_cnt;
    w_pass_nxt              = r_pass_cnt;
    bus.data_in_ready       = 1'b0;
    bus.data_out_valid      = 1'b0;
    bus.data_out_last       = w_beat_last;
    bus.data_out_block_last = w_beat_last && (r_pass_cnt == PW'(REPEAT - 1));
    bus.pass_index          = r_pass_cnt;
    for (int k = 0; k < BEAT_SIZE; k++) begin
      bus.data_out[k] = bus.data_in[k];
    end

    if (r_state == FILL) begin
      bus.data_in_ready  = bus.data_out_ready;
      bus.data_out_valid = bus.data_in_valid;
    end else begin
      bus.data_out_valid = 1'b1;
      for (int k = 0; k < BEAT_SIZE; k++) begin
        bus.data_out[k] = r_mem[r_beat_cnt][k];
      end
    end

    if (w_xfer) begin
      if (w_beat_last) begin
        w_beat_nxt = '0;
        if (r_state == FILL) begin
          if (REPEAT > 1) begin
            w_state_nxt = REPLAY;
            w_pass_nxt  = PW'(1);
          end
        end else if (r_pass_cnt == PW'(REPEAT - 1)) begin
          w_pass_nxt  = '0;
          w_state_nxt = FILL;
        end else begin
          w_pass_nxt = r_pass_cnt + PW'(1);
        end
      end else begin
        w_beat_nxt = r_beat_cnt + BW'(1);
      end
    end
  end
endmodule

// File: tb/tb_matmul_row_block_replay.sv
// tb/tb_matmul_row_block_replay.sv - randomized reference-model bench for the row-block replay stage
module tb_matmul_row_block_replay;
  logic clk;
  logic rst;

  matmul_row_block_replay_if #(.DATA_WIDTH(8), .BEAT_SIZE(4), .REPEAT(2)) if_a ();
  matmul_row_block_replay_if #(.DATA_WIDTH(8), .BEAT_SIZE(4), .REPEAT(1)) if_b ();
  matmul_row_block_replay_if #(.DATA_WIDTH(8), .BEAT_SIZE(4), .REPEAT(3)) if_c ();

  matmul_row_block_replay #(.DATA_WIDTH(8), .BEAT_SIZE(4), .DEPTH(3), .REPEAT(2))
    u_def (.clk(clk), .rst(rst), .bus(if_a));
  matmul_row_block_replay #(.DATA_WIDTH(8), .BEAT_SIZE(4), .DEPTH(4), .REPEAT(1))
    u_r1 (.clk(clk), .rst(rst), .bus(if_b));
  matmul_row_block_replay #(.DATA_WIDTH(8), .BEAT_SIZE(4), .DEPTH(1), .REPEAT(3))
    u_d1 (.clk(clk), .rst(rst), .bus(if_c));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model: output position within a block of DEPTH*REPEAT beats
  int          dep [3] = '{3, 4, 1};
  int          rep [3] = '{2, 1, 3};
  int          pos [3] = '{0, 0, 0};
  logic [31:0] blk [3][4];
  logic        stalled [3] = '{1'b0, 1'b0, 1'b0};
  logic [31:0] prev_od [3];
  int          nxfer = 0;
  logic        g_hold = 1'b0;
  logic        g_ir, g_bl;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int sel, input logic [31:0] d, input logic v, input logic r);
    case (sel)
      0: begin
        for (int k = 0; k < 4; k++) if_a.data_in[k] = d[8*k +: 8];
        if_a.data_in_valid = v; if_a.data_out_ready = r;
      end
      1: begin
        for (int k = 0; k < 4; k++) if_b.data_in[k] = d[8*k +: 8];
        if_b.data_in_valid = v; if_b.data_out_ready = r;
      end
      default: begin
        for (int k = 0; k < 4; k++) if_c.data_in[k] = d[8*k +: 8];
        if_c.data_in_valid = v; if_c.data_out_ready = r;
      end
    endcase
  endtask

  task automatic sample(input int sel, output logic [31:0] d, output logic v, output logic ir,
                        output logic l, output logic bl, output int p);
    case (sel)
      0: begin
        for (int k = 0; k < 4; k++) d[8*k +: 8] = if_a.data_out[k];
        v = if_a.data_out_valid; ir = if_a.data_in_ready; l = if_a.data_out_last;
        bl = if_a.data_out_block_last; p = int'(if_a.pass_index);
      end
      1: begin
        for (int k = 0; k < 4; k++) d[8*k +: 8] = if_b.data_out[k];
        v = if_b.data_out_valid; ir = if_b.data_in_ready; l = if_b.data_out_last;
        bl = if_b.data_out_block_last; p = int'(if_b.pass_index);
      end
      default: begin
        for (int k = 0; k < 4; k++) d[8*k +: 8] = if_c.data_out[k];
        v = if_c.data_out_valid; ir = if_c.data_in_ready; l = if_c.data_out_last;
        bl = if_c.data_out_block_last; p = int'(if_c.pass_index);
      end
    endcase
  endtask

  // One clock cycle on one instance: drive, check against model mid-cycle, advance model on the edge
  task automatic step(input int sel, input logic [31:0] d, input logic v, input logic r);
    logic [31:0] od, ed;
    logic        ov, oir, ol, obl, ev, eir, xfer;
    int          op, ps, bt;
    drive(sel, d, v, r);
    #3;
    sample(sel, od, ov, oir, ol, obl, op);
    ps = pos[sel] / dep[sel];
    bt = pos[sel] % dep[sel];
    if (ps == 0) begin
      ev = v; eir = r; ed = d;
    end else begin
      ev = 1'b1; eir = 1'b0; ed = blk[sel][bt];
    end
    chk("out_valid", ov, ev);
    chk("in_ready", oir, eir);
    if (ev) begin
      chk("data_out", od, ed);
      chk("last", ol, (bt == dep[sel] - 1));
      chk("block_last", obl, (bt == dep[sel] - 1) && (ps == rep[sel] - 1));
      chk("pass_index", op, ps);
    end
    if (stalled[sel] && ev) chk("stable", od, prev_od[sel]);
    stalled[sel] = ev && !r;
    prev_od[sel] = od;
    g_hold = (ps == 0) && v && !r;
    g_ir = oir;
    g_bl = obl;
    xfer = ev && r;
    @(posedge clk);
    #1;
    if (xfer) begin
      if (ps == 0) blk[sel][bt] = d;
      pos[sel] = (pos[sel] + 1) % (dep[sel] * rep[sel]);
      nxfer++;
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a [3];
    logic [31:0] d, od;
    logic        v, r, ov, oir, ol, obl;
    int          op, cyc, low_ir, bl_cnt, bl_at;

    rst = 1'b0;
    drive(0, 32'h0, 1'b0, 1'b0);
    drive(1, 32'h0, 1'b0, 1'b0);
    drive(2, 32'h0, 1'b0, 1'b0);

    // Reset state: FILL pass-through
    drive(0, 32'hdeadbeef, 1'b1, 1'b0);
    drive(2, 32'h0, 1'b0, 1'b1);
    #3;
    sample(0, od, ov, oir, ol, obl, op);
    chk("rst_valid", ov, 1'b1);
    chk("rst_in_ready", oir, 1'b0);
    chk("rst_data", od, 32'hdeadbeef);
    chk("rst_last", ol, 1'b0);
    chk("rst_block_last", obl, 1'b0);
    chk("rst_pass", op, 0);
    sample(2, od, ov, oir, ol, obl, op);
    chk("rst_d1_valid", ov, 1'b0);
    chk("rst_d1_in_ready", oir, 1'b1);
    chk("rst_d1_last", ol, 1'b1);
    chk("rst_d1_block_last", obl, 1'b0);
    #9 rst = 1'b1;
    drive(0, 32'h0, 1'b0, 1'b0);
    drive(2, 32'h0, 1'b0, 1'b0);
    @(posedge clk);
    #1;

    // Directed block A0..A2 with continuous ready
    for (int b = 0; b < 3; b++)
      for (int k = 0; k < 4; k++) a[b][8*k +: 8] = 8'(16 * b + k);
    low_ir = 0; bl_cnt = 0; bl_at = -1; nxfer = 0;
    for (int c = 0; c < 6; c++) begin
      step(0, (c < 3) ? a[c] : 32'h5a5a5a5a, 1'b1, 1'b1);
      if (!g_ir) low_ir++;
      if (g_bl) begin bl_cnt++; bl_at = c; end
    end
    chk("dir_xfers", nxfer, 6);
    chk("dir_in_ready_low", low_ir, 3);
    chk("dir_block_last_cnt", bl_cnt, 1);
    chk("dir_block_last_at", bl_at, 5);

    // Random ready at 50%, random source valid, 20 blocks
    nxfer = 0; cyc = 0; g_hold = 1'b0; d = '0; v = 1'b0;
    while (nxfer < 120 && cyc < 3000) begin
      if (!g_hold) begin
        d = $urandom;
        v = ($urandom_range(0, 3) != 0);
      end
      r = 1'($urandom_range(0, 1));
      step(0, d, v, r);
      cyc++;
    end
    chk("rand_xfers", nxfer, 120);

    // Back-to-back blocks, valid and ready held high
    nxfer = 0;
    for (int c = 0; c < 12; c++) step(0, $urandom, 1'b1, 1'b1);
    chk("b2b_xfers", nxfer, 12);
    drive(0, 32'h0, 1'b0, 1'b0);

    // REPEAT=1, DEPTH=4: pure wire
    g_hold = 1'b0; nxfer = 0;
    for (int c = 0; c < 24; c++) begin
      if (!g_hold) begin
        d = $urandom;
        v = 1'($urandom_range(0, 1));
      end
      r = 1'($urandom_range(0, 1));
      step(1, d, v, r);
    end
    drive(1, 32'h0, 1'b0, 1'b0);

    // DEPTH=1, REPEAT=3: X,X,X,Y,Y,Y
    nxfer = 0;
    step(2, 32'h11223344, 1'b1, 1'b1);
    step(2, 32'h0, 1'b0, 1'b1);
    step(2, 32'h0, 1'b0, 1'b1);
    step(2, 32'hcafef00d, 1'b1, 1'b1);
    step(2, 32'h0, 1'b1, 1'b1);
    step(2, 32'h0, 1'b1, 1'b1);
    chk("d1_xfers", nxfer, 6);
    drive(2, 32'h0, 1'b0, 1'b0);

    // Asynchronous reset during pass 1, beat 1
    for (int b = 0; b < 3; b++) a[b] = $urandom;
    for (int c = 0; c < 4; c++) step(0, (c < 3) ? a[c] : 32'h0, 1'b1, 1'b1);
    chk("pre_rst_pos", pos[0], 4);
    drive(0, 32'h0badf00d, 1'b1, 1'b1);
    #1 rst = 1'b0;
    #1;
    sample(0, od, ov, oir, ol, obl, op);
    chk("arst_valid", ov, 1'b1);
    chk("arst_in_ready", oir, 1'b1);
    chk("arst_pass", op, 0);
    chk("arst_data", od, 32'h0badf00d);
    chk("arst_last", ol, 1'b0);
    drive(0, 32'h0badf00d, 1'b0, 1'b0);
    #1;
    sample(0, od, ov, oir, ol, obl, op);
    chk("arst_valid_lo", ov, 1'b0);
    chk("arst_in_ready_lo", oir, 1'b0);
    for (int s = 0; s < 3; s++) begin pos[s] = 0; stalled[s] = 1'b0; end
    @(posedge clk);
    #2 rst = 1'b1;

    // New block B (bitwise complement of A) must replay without stale A data
    nxfer = 0;
    for (int c = 0; c < 6; c++) step(0, (c < 3) ? ~a[c] : 32'h0, 1'b1, 1'b1);
    chk("post_rst_xfers", nxfer, 6);
    drive(0, 32'h0, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
